shift_deser16: RTL and testbench

SHIFT_DESER16 -- requirements
Module: shift_deser16

---
 rtl/shift_deser16.sv | 107 ++++++++++
 tb/tb_shift_deser16.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deser16.sv
// rtl/shift_deser16.sv - serial-to-parallel deserialiser with valid/ready handshakes on both sides
// Assembles WIDTH serial beats into a word; only the completing beat can be stalled by a full output.
module shift_deser16 #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_pad,
    input  logic             rst_n_pad,
    input  logic             sin_pad,
    input  logic             sin_vld_pad,
    output logic             sin_rdy_pad,
    input  logic             clr_pad,
    output logic [WIDTH-1:0] dout_pad,
    output logic             dout_vld_pad,
    input  logic             dout_rdy_pad,
    output logic             ovf_pad
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_HOLD,
        S_STALL
    } state_t;

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             ovf_q, ovf_d;

    state_t           cur_state;
    logic             sin_rdy;
    logic             beat;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        cur_state = S_IDLE;
        if ((cnt_q == LAST) && dout_vld_q && !dout_rdy_pad) begin
            cur_state = S_STALL;
        end else if (cnt_q != '0) begin
            cur_state = S_FILL;
        end else if (dout_vld_q) begin
            cur_state = S_HOLD;
        end
    end

    always_comb begin
        sin_rdy = (cur_state != S_STALL);
        beat    = sin_vld_pad && sin_rdy && !clr_pad;
        if (MSB_FIRST) begin
            shifted = {sreg_q[WIDTH-2:0], sin_pad};
        end else begin
            shifted = {sin_pad, sreg_q[WIDTH-1:1]};
        end

        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        ovf_d      = ovf_q;

        if (clr_pad) begin
            sreg_d = '0;
            cnt_d  = '0;
            // Aborting while stalled throws away a complete word.
            if (cur_state == S_STALL && sin_vld_pad) begin
                ovf_d = 1'b1;
            end
        end else if (beat) begin
            sreg_d = shifted;
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end

        if (beat && (cnt_q == LAST)) begin
            dout_d     = shifted;
            dout_vld_d = 1'b1;
        end else if (dout_vld_q && dout_rdy_pad) begin
            dout_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) begin
            sreg_q     <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign sin_rdy_pad  = sin_rdy;
    assign dout_pad     = dout_q;
    assign dout_vld_pad = dout_vld_q;
    assign ovf_pad      = ovf_q;

endmodule

// File: tb/tb_shift_deser16.sv
// tb/tb_shift_deser16.sv - bench for shift_deser16, MSB-first and LSB-first instances on shared stimulus
module tb_shift_deser16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b0;
    logic        sin_vld = 1'b0;
    logic        clr = 1'b0;
    logic        dout_rdy = 1'b0;
    logic        sin_rdy, sin_rdy_l;
    logic [15:0] dout, dout_l;
    logic        dout_vld, dout_vld_l;
    logic        ovf, ovf_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_deser16 #(.WIDTH(16), .MSB_FIRST(1'b1)) dut (
        .clk_pad(clk), .rst_n_pad(rst_n), .sin_pad(sin), .sin_vld_pad(sin_vld),
        .sin_rdy_pad(sin_rdy), .clr_pad(clr), .dout_pad(dout), .dout_vld_pad(dout_vld),
        .dout_rdy_pad(dout_rdy), .ovf_pad(ovf)
    );

    shift_deser16 #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
        .clk_pad(clk), .rst_n_pad(rst_n), .sin_pad(sin), .sin_vld_pad(sin_vld),
        .sin_rdy_pad(sin_rdy_l), .clr_pad(clr), .dout_pad(dout_l), .dout_vld_pad(dout_vld_l),
        .dout_rdy_pad(dout_rdy), .ovf_pad(ovf_l)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Sends the first nbits of w, first bit = w[15]; dout_rdy raised on chosen beats.
    task automatic send_word(input logic [15:0] w, input bit rdy_first, input bit rdy_last,
                             input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sin      = w[15-i];
            sin_vld  = 1'b1;
            dout_rdy = (i == 0) ? rdy_first : ((i == 15) ? rdy_last : 1'b0);
            @(negedge clk);
        end
        sin_vld  = 1'b0;
        dout_rdy = 1'b0;
    endtask

    typedef struct {
        logic [15:0] stream;
        logic [15:0] exp_msb;
        logic [15:0] exp_lsb;
    } vec_t;

    vec_t vecs[4];

    // Reference model state for the random phase
    bit          m_bits[$];
    bit          m_full;
    logic [15:0] m_word, m_word_l;
    bit          m_ovf;

    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3, 16'hC3A5};
        vecs[1] = '{16'h8000, 16'h8000, 16'h0001};
        vecs[2] = '{16'h1234, 16'h1234, 16'h2C48};
        vecs[3] = '{16'h0001, 16'h0001, 16'h8000};

        @(negedge clk);
        #1;
        chk("reset dout", dout, 16'h0);
        chk("reset dout_vld", dout_vld, 1'b0);
        chk("reset ovf", ovf, 1'b0);
        chk("reset sin_rdy", sin_rdy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Word assembly, both bit orders
        for (int v = 0; v < 4; v++) begin
            send_word(vecs[v].stream, 1'b1, 1'b0, 16);
            #1;
            chk("table dout", dout, vecs[v].exp_msb);
            chk("table dout_l", dout_l, vecs[v].exp_lsb);
            chk("table dout_vld", dout_vld, 1'b1);
            chk("table ovf", ovf, 1'b0);
            @(negedge clk);
        end

        // Back-to-back words with the read landing on the completing beat
        send_word(16'h0001, 1'b1, 1'b0, 16);
        for (int i = 0; i < 16; i++) begin
            sin      = 1'b1;
            sin_vld  = 1'b1;
            dout_rdy = (i == 15);
            #1;
            chk("b2b sin_rdy", sin_rdy, 1'b1);
            chk("b2b dout_vld", dout_vld, 1'b1);
            chk("b2b dout old", dout, 16'h0001);
            @(negedge clk);
        end
        sin_vld  = 1'b0;
        dout_rdy = 1'b0;
        #1;
        chk("b2b dout new", dout, 16'hFFFF);
        chk("b2b dout_vld new", dout_vld, 1'b1);

        // Backpressure on the completing beat
        @(negedge clk);
        send_word(16'h5A5A, 1'b0, 1'b0, 15);
        sin     = 1'b0;
        sin_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp stall", sin_rdy, 1'b0);
            chk("bp hold dout", dout, 16'hFFFF);
            @(negedge clk);
        end
        dout_rdy = 1'b1;
        #1;
        chk("bp release", sin_rdy, 1'b1);
        @(negedge clk);
        sin_vld  = 1'b0;
        dout_rdy = 1'b0;
        #1;
        chk("bp new dout", dout, 16'h5A5A);
        chk("bp new vld", dout_vld, 1'b1);

        // Abort of a partial word
        @(negedge clk);
        dout_rdy = 1'b1;
        @(negedge clk);
        dout_rdy = 1'b0;
        send_word(16'hFFFF, 1'b0, 1'b0, 7);
        clr     = 1'b1;
        sin     = 1'b1;
        sin_vld = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        sin_vld = 1'b0;
        send_word(16'h1234, 1'b0, 1'b0, 16);
        #1;
        chk("abort dout", dout, 16'h1234);
        chk("abort dout_l", dout_l, 16'h2C48);
        chk("abort ovf", ovf, 1'b0);

        // Abort while stalled discards a full word
        @(negedge clk);
        send_word(16'hABCD, 1'b0, 1'b0, 15);
        sin     = 1'b1;
        sin_vld = 1'b1;
        clr     = 1'b1;
        #1;
        chk("ovf stall", sin_rdy, 1'b0);
        @(negedge clk);
        clr     = 1'b0;
        sin_vld = 1'b0;
        #1;
        chk("ovf set", ovf, 1'b1);
        chk("ovf dout kept", dout, 16'h1234);
        chk("ovf vld kept", dout_vld, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("ovf sticky", ovf, 1'b1);
        chk("ovf cnt cleared", sin_rdy, 1'b1);

        // Asynchronous reset mid-word with a word held
        @(negedge clk);
        send_word(16'h0FF0, 1'b0, 1'b0, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset dout", dout, 16'h0);
        chk("areset vld", dout_vld, 1'b0);
        chk("areset ovf", ovf, 1'b0);
        chk("areset sin_rdy", sin_rdy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(16'hC0DE, 1'b0, 1'b0, 16);
        #1;
        chk("areset fresh", dout, 16'hC0DE);
        chk("areset fresh_l", dout_l, 16'h7B03);
        chk("areset fresh vld", dout_vld, 1'b1);

        // Randomised traffic against a bit-queue model
        m_bits.delete();
        m_full   = 1'b1;
        m_word   = 16'hC0DE;
        m_word_l = 16'h7B03;
        m_ovf    = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            bit exp_rdy;
            bit done;
            sin      = $urandom_range(0, 1);
            sin_vld  = ($urandom_range(0, 3) != 0);
            dout_rdy = ($urandom_range(0, 2) == 0);
            clr      = ($urandom_range(0, 59) == 0);
            #1;
            exp_rdy = !(m_bits.size() == 15 && m_full && !dout_rdy);
            chk("rnd sin_rdy", sin_rdy, exp_rdy);
            chk("rnd dout_vld", dout_vld, m_full);
            chk("rnd ovf", ovf, m_ovf);
            if (m_full) begin
                chk("rnd dout", dout, m_word);
                chk("rnd dout_l", dout_l, m_word_l);
            end
            done = 1'b0;
            if (clr) begin
                if (m_bits.size() == 15 && sin_vld && !exp_rdy) m_ovf = 1'b1;
                m_bits.delete();
            end else if (sin_vld && exp_rdy) begin
                m_bits.push_back(sin);
                if (m_bits.size() == 16) begin
                    m_word   = '0;
                    m_word_l = '0;
                    for (int i = 0; i < 16; i++) begin
                        m_word   = m_word   | (16'(m_bits[i]) << (15 - i));
                        m_word_l = m_word_l | (16'(m_bits[i]) << i);
                    end
                    m_bits.delete();
                    done = 1'b1;
                end
            end
            if (done) m_full = 1'b1;
            else if (m_full && dout_rdy) m_full = 1'b0;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
